// File: rtl/riscv_load_writeback_unit_pkg.sv
// Shared types and constants for the RV32I load/writeback stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package riscv_load_writeback_unit_pkg;

  localparam int LSU_XLEN = 32;

  // RV32I load funct3 encodings
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_WB   = 2'd3
  } lsu_state_e;

  // A load is rejected when funct3 is not a load, or the access is not
  // naturally aligned for its size.
  function automatic logic load_is_bad(input logic [2:0] funct3, input logic [1:0] off);
    logic bad;
    bad = 1'b0;
    case (funct3)
      F3_LB, F3_LBU: bad = 1'b0;
      F3_LH, F3_LHU: bad = off[0];
      F3_LW:         bad = (off != 2'b00);
      default:       bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/riscv_load_writeback_unit_extract.sv
// Selects the addressed byte/halfword/word from a read word and sign/zero extends it.
// Latency: purely combinational.
// Backpressure: none.
module riscv_load_extract
  import riscv_load_writeback_unit_pkg::*;
(
  input  logic [2:0]          i_funct3,
  input  logic [1:0]          i_offset,
  input  logic [LSU_XLEN-1:0] i_word,
  output logic [LSU_XLEN-1:0] o_data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Lane selection followed by extension according to load type
  always_comb begin
    byte_v = i_word[8*i_offset +: 8];
    half_v = i_offset[1] ? i_word[31:16] : i_word[15:0];
    o_data = i_word;
    case (i_funct3)
      F3_LB:   o_data = {{24{byte_v[7]}}, byte_v};
      F3_LBU:  o_data = {24'd0, byte_v};
      F3_LH:   o_data = {{16{half_v[15]}}, half_v};
      F3_LHU:  o_data = {16'd0, half_v};
      default: o_data = i_word;
    endcase
  end

endmodule

// File: rtl/riscv_load_writeback_unit.sv
// RV32I load unit: issues a word read to data memory and writes the extracted value to rd.
// Latency: accept at N, request at N+1, writeback at N+2 when gnt and rvalid arrive on the first request cycle.
// Backpressure: o_lsu_ready is high only when idle; o_dmem_req holds with stable address until i_dmem_gnt.
module riscv_load_writeback_unit
  import riscv_load_writeback_unit_pkg::*;
#(
  parameter int XLEN           = LSU_XLEN,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_lsu_valid,
  output logic            o_lsu_ready,
  input  logic [2:0]      i_lsu_funct3,
  input  logic [XLEN-1:0] i_lsu_addr,
  input  logic [4:0]      i_lsu_rd_addr,
  output logic            o_lsu_busy,
  output logic [4:0]      o_lsu_pending_rd,
  output logic            o_lsu_fault,
  output logic            o_dmem_req,
  output logic [XLEN-1:0] o_dmem_addr,
  input  logic            i_dmem_gnt,
  input  logic            i_dmem_rvalid,
  input  logic [XLEN-1:0] i_dmem_rdata,
  output logic            o_regfile_rd_wen,
  output logic [4:0]      o_regfile_rd_addr,
  output logic [XLEN-1:0] o_regfile_rd_data
);

  localparam logic [7:0] TIMEOUT_LIMIT = TIMEOUT_CYCLES[7:0];

  lsu_state_e      state_q, state_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [1:0]      off_q, off_d;
  logic [4:0]      rd_q, rd_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [7:0]      cnt_inc;
  logic [XLEN-1:0] addr_d;

  logic            ready_q, ready_d;
  logic            busy_q, busy_d;
  logic [4:0]      pending_rd_q, pending_rd_d;
  logic            fault_q, fault_d;
  logic            dmem_req_q, dmem_req_d;
  logic [XLEN-1:0] dmem_addr_q, dmem_addr_d;
  logic            wen_q, wen_d;
  logic [4:0]      rd_addr_q, rd_addr_d;
  logic [XLEN-1:0] rd_data_q, rd_data_d;

  logic [XLEN-1:0] ext_data;

  riscv_load_extract u_extract (
    .i_funct3 (funct3_q),
    .i_offset (off_q),
    .i_word   (i_dmem_rdata),
    .o_data   (ext_data)
  );

  // Next-state and registered-output computation
  always_comb begin
    state_d     = state_q;
    funct3_d    = funct3_q;
    off_d       = off_q;
    rd_d        = rd_q;
    cnt_d       = cnt_q;
    cnt_inc     = cnt_q + 8'd1;
    addr_d      = dmem_addr_q;
    fault_d     = 1'b0;
    wen_d       = 1'b0;
    rd_addr_d   = 5'd0;
    rd_data_d   = '0;

    case (state_q)
      ST_IDLE: begin
        if (i_lsu_valid && ready_q) begin
          funct3_d = i_lsu_funct3;
          off_d    = i_lsu_addr[1:0];
          rd_d     = i_lsu_rd_addr;
          if (load_is_bad(i_lsu_funct3, i_lsu_addr[1:0])) begin
            fault_d = 1'b1;
          end else begin
            state_d = ST_REQ;
            addr_d  = {i_lsu_addr[XLEN-1:2], 2'b00};
          end
        end
      end
      ST_REQ: begin
        // Responses are only meaningful once the request has been granted
        if (i_dmem_gnt) begin
          if (i_dmem_rvalid) begin
            state_d   = ST_WB;
            wen_d     = (rd_q != 5'd0);
            rd_addr_d = rd_q;
            rd_data_d = ext_data;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = 8'd0;
          end
        end
      end
      ST_WAIT: begin
        if (i_dmem_rvalid) begin
          state_d   = ST_WB;
          wen_d     = (rd_q != 5'd0);
          rd_addr_d = rd_q;
          rd_data_d = ext_data;
        end else if (cnt_inc == TIMEOUT_LIMIT) begin
          state_d = ST_IDLE;
          fault_d = 1'b1;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_WB: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Status and memory outputs are registered images of the next state
    ready_d      = (state_d == ST_IDLE);
    busy_d       = (state_d != ST_IDLE);
    pending_rd_d = busy_d ? rd_d : 5'd0;
    dmem_req_d   = (state_d == ST_REQ);
    dmem_addr_d  = (state_d == ST_REQ) ? addr_d : '0;
  end

  // State, context and output registers with asynchronous reset
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= ST_IDLE;
      funct3_q     <= 3'd0;
      off_q        <= 2'd0;
      rd_q         <= 5'd0;
      cnt_q        <= 8'd0;
      ready_q      <= 1'b1;
      busy_q       <= 1'b0;
      pending_rd_q <= 5'd0;
      fault_q      <= 1'b0;
      dmem_req_q   <= 1'b0;
      dmem_addr_q  <= '0;
      wen_q        <= 1'b0;
      rd_addr_q    <= 5'd0;
      rd_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      funct3_q     <= funct3_d;
      off_q        <= off_d;
      rd_q         <= rd_d;
      cnt_q        <= cnt_d;
      ready_q      <= ready_d;
      busy_q       <= busy_d;
      pending_rd_q <= pending_rd_d;
      fault_q      <= fault_d;
      dmem_req_q   <= dmem_req_d;
      dmem_addr_q  <= dmem_addr_d;
      wen_q        <= wen_d;
      rd_addr_q    <= rd_addr_d;
      rd_data_q    <= rd_data_d;
    end
  end

  assign o_lsu_ready       = ready_q;
  assign o_lsu_busy        = busy_q;
  assign o_lsu_pending_rd  = pending_rd_q;
  assign o_lsu_fault       = fault_q;
  assign o_dmem_req        = dmem_req_q;
  assign o_dmem_addr       = dmem_addr_q;
  assign o_regfile_rd_wen  = wen_q;
  assign o_regfile_rd_addr = rd_addr_q;
  assign o_regfile_rd_data = rd_data_q;

endmodule

// File: tb/tb_riscv_load_writeback_unit.sv
// Self-checking bench for riscv_load_writeback_unit with a writeback/fault scoreboard.
// Latency: checks request at N+1 and writeback at N+2 on the fast path.
// Backpressure: exercises delayed grant, delayed response, timeout and reset abort.
module tb_riscv_load_writeback_unit;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        lsu_valid;
  logic        ready;
  logic [2:0]  lsu_f3;
  logic [31:0] lsu_addr;
  logic [4:0]  lsu_rd;
  logic        busy;
  logic [4:0]  pend_rd;
  logic        fault;
  logic        req;
  logic [31:0] dmem_addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        wen;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;

  typedef struct {
    bit          is_fault;
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_fail   = 0;
  int wen_cnt  = 0;
  int exp_wen  = 0;

  always #5 clk = ~clk;

  riscv_load_writeback_unit #(.XLEN(32), .TIMEOUT_CYCLES(TO)) dut (
    .i_clk             (clk),
    .i_rst             (rst),
    .i_lsu_valid       (lsu_valid),
    .o_lsu_ready       (ready),
    .i_lsu_funct3      (lsu_f3),
    .i_lsu_addr        (lsu_addr),
    .i_lsu_rd_addr     (lsu_rd),
    .o_lsu_busy        (busy),
    .o_lsu_pending_rd  (pend_rd),
    .o_lsu_fault       (fault),
    .o_dmem_req        (req),
    .o_dmem_addr       (dmem_addr),
    .i_dmem_gnt        (gnt),
    .i_dmem_rvalid     (rvalid),
    .i_dmem_rdata      (rdata),
    .o_regfile_rd_wen  (wen),
    .o_regfile_rd_addr (rd_addr),
    .o_regfile_rd_data (rd_data)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit model_bad(input logic [2:0] f3, input logic [31:0] a);
    if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) return 1'b1;
    if ((f3 == 3'b001 || f3 == 3'b101) && a[0]) return 1'b1;
    if (f3 == 3'b010 && a[1:0] != 2'b00) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] w);
    logic [31:0] b;
    logic [31:0] h;
    b = w >> (8 * off);
    h = off[1] ? (w >> 16) : w;
    case (f3)
      3'b000:  return {{24{b[7]}}, b[7:0]};
      3'b100:  return {24'd0, b[7:0]};
      3'b001:  return {{16{h[15]}}, h[15:0]};
      3'b101:  return {16'd0, h[15:0]};
      default: return w;
    endcase
  endfunction

  // Scoreboard: every writeback or fault pulse must match the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    if (!rst && (wen || fault)) begin
      check("sb_has_entry", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("sb_kind_fault", 32'(fault), 32'(e.is_fault));
        if (!e.is_fault) begin
          check("sb_rd_addr", 32'(rd_addr), 32'(e.rd));
          check("sb_rd_data", rd_data, e.data);
        end
      end
    end
    if (wen) wen_cnt++;
  end

  task automatic accept(input logic [2:0] f3, input logic [31:0] a, input logic [4:0] rd);
    int budget;
    budget = 0;
    while (!ready && budget < 50) begin
      @(posedge clk); #1;
      budget++;
    end
    check("ready_before_accept", 32'(ready), 32'd1);
    lsu_valid = 1'b1;
    lsu_f3    = f3;
    lsu_addr  = a;
    lsu_rd    = rd;
    @(posedge clk); #1;
    lsu_valid = 1'b0;
    lsu_f3    = 3'b111;
    lsu_addr  = 32'hFFFF_FFFF;
  endtask

  // rv_dly < 0 means the response never arrives
  task automatic run_load(input logic [2:0] f3, input logic [31:0] a, input logic [4:0] rd,
                          input logic [31:0] word, input int gnt_dly, input int rv_dly);
    bit          bad;
    logic [31:0] expv;
    bad  = model_bad(f3, a);
    expv = ref_load(f3, a[1:0], word);
    if (bad || rv_dly < 0) begin
      sb.push_back('{1'b1, 5'd0, 32'd0});
    end else if (rd != 5'd0) begin
      sb.push_back('{1'b0, rd, expv});
      exp_wen++;
    end
    accept(f3, a, rd);
    if (bad) begin
      @(negedge clk);
      check("bad_no_req", 32'(req), 32'd0);
      check("bad_ready", 32'(ready), 32'd1);
      check("bad_fault_pulse", 32'(fault), 32'd1);
      check("bad_no_wen", 32'(wen), 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      check("bad_fault_one_cycle", 32'(fault), 32'd0);
      check("bad_no_req_later", 32'(req), 32'd0);
      @(posedge clk); #1;
      return;
    end
    for (int k = 0; k <= gnt_dly; k++) begin
      if (k == gnt_dly) begin
        gnt = 1'b1;
        if (rv_dly == 0) begin
          rvalid = 1'b1;
          rdata  = word;
        end
      end
      @(negedge clk);
      check("req_held", 32'(req), 32'd1);
      check("req_addr", dmem_addr, {a[31:2], 2'b00});
      check("busy_req", 32'(busy), 32'd1);
      check("pend_req", 32'(pend_rd), 32'(rd));
      @(posedge clk); #1;
      gnt    = 1'b0;
      rvalid = 1'b0;
      rdata  = $urandom;
    end
    if (rv_dly < 0) begin
      for (int j = 0; j < TO; j++) begin
        @(negedge clk);
        check("to_wait_busy", 32'(busy), 32'd1);
        check("to_no_fault_yet", 32'(fault), 32'd0);
        check("wait_no_req", 32'(req), 32'd0);
        @(posedge clk); #1;
      end
      @(negedge clk);
      check("to_fault", 32'(fault), 32'd1);
      check("to_ready", 32'(ready), 32'd1);
      check("to_no_wen", 32'(wen), 32'd0);
      @(posedge clk); #1;
      return;
    end
    for (int j = 1; j <= rv_dly; j++) begin
      if (j == rv_dly) begin
        rvalid = 1'b1;
        rdata  = word;
      end
      @(negedge clk);
      check("wait_no_req", 32'(req), 32'd0);
      check("busy_wait", 32'(busy), 32'd1);
      check("pend_wait", 32'(pend_rd), 32'(rd));
      @(posedge clk); #1;
      rvalid = 1'b0;
      rdata  = $urandom;
    end
    @(negedge clk);
    check("wb_wen", 32'(wen), 32'(rd != 5'd0));
    check("wb_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("after_wb_ready", 32'(ready), 32'd1);
    check("after_wb_no_wen", 32'(wen), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 32'(ready), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_pend"}, 32'(pend_rd), 32'd0);
    check({tag, "_fault"}, 32'(fault), 32'd0);
    check({tag, "_req"}, 32'(req), 32'd0);
    check({tag, "_addr"}, dmem_addr, 32'd0);
    check({tag, "_wen"}, 32'(wen), 32'd0);
    check({tag, "_rd_addr"}, 32'(rd_addr), 32'd0);
    check({tag, "_rd_data"}, rd_data, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int wen_before;
    rst = 1'b1; lsu_valid = 1'b0; lsu_f3 = 3'd0; lsu_addr = 32'd0; lsu_rd = 5'd0;
    gnt = 1'b0; rvalid = 1'b0; rdata = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    // Stale response right after reset must be ignored
    rvalid = 1'b1; rdata = 32'hCAFE_F00D;
    rst = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rvalid = 1'b0;
    @(negedge clk);
    check("stale_no_wen", 32'(wen_cnt), 32'd0);
    check("stale_idle", 32'(busy), 32'd0);
    @(posedge clk); #1;

    // Fast path LW, then byte/half extraction patterns
    run_load(3'b010, 32'h0000_0100, 5'd5, 32'hDEAD_BEEF, 0, 0);
    run_load(3'b000, 32'h0000_0203, 5'd6, 32'h80FF_1234, 0, 0);
    run_load(3'b100, 32'h0000_0203, 5'd7, 32'h80FF_1234, 0, 0);
    run_load(3'b001, 32'h0000_0202, 5'd8, 32'h80FF_1234, 0, 0);
    run_load(3'b101, 32'h0000_0202, 5'd9, 32'h80FF_1234, 1, 1);
    run_load(3'b000, 32'h0000_0011, 5'd10, 32'h1234_F67F, 0, 2);
    run_load(3'b001, 32'h0000_0020, 5'd11, 32'h0000_9ABC, 2, 0);

    // Rejected loads
    run_load(3'b001, 32'h0000_0101, 5'd12, 32'd0, 0, 0);
    run_load(3'b011, 32'h0000_0100, 5'd13, 32'd0, 0, 0);
    run_load(3'b010, 32'h0000_0102, 5'd14, 32'd0, 0, 0);

    // Delayed grant and response
    run_load(3'b010, 32'h0000_0500, 5'd15, 32'h0BAD_F00D, 3, 4);

    // Response timeout
    run_load(3'b010, 32'h0000_0600, 5'd16, 32'd0, 0, -1);

    // Reset while waiting for the response
    wen_before = wen_cnt;
    accept(3'b010, 32'h0000_0300, 5'd17);
    gnt = 1'b1;
    @(negedge clk);
    check("rst_case_req", 32'(req), 32'd1);
    @(posedge clk); #1;
    gnt = 1'b0;
    @(negedge clk);
    check("rst_case_wait_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    rvalid = 1'b1; rdata = 32'h1234_5678;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rvalid = 1'b0;
    @(negedge clk);
    check("midrst_no_write", 32'(wen_cnt), 32'(wen_before));
    check("midrst_idle", 32'(busy), 32'd0);
    @(posedge clk); #1;

    // rd = 0 passes through WB without a write
    run_load(3'b010, 32'h0000_0400, 5'd0, 32'h5555_AAAA, 1, 2);

    repeat (3) begin @(posedge clk); #1; end
    check("wen_count", 32'(wen_cnt), 32'(exp_wen));
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/riscv_load_writeback_unit.md
Name: riscv_load_writeback_unit

Overview:
Load/writeback stage that executes RV32I loads (LB/LH/LW/LBU/LHU) and feeds the register-file write port. It accepts one load per handshake and issues a word-aligned request to data memory. It waits for the response, then extracts and sign- or zero-extends the addressed byte/halfword. The result is written to rd with a one-cycle write-enable pulse. Misaligned accesses, illegal funct3 values and response timeouts raise a fault pulse instead of writing back.

Parameters:
XLEN, 32, datapath width; the block supports only 32.
TIMEOUT_CYCLES, 255, maximum cycles spent in WAIT before a fault; range 1..255.

Ports:
i_clk  input  1  clock, rising edge
i_rst  input  1  asynchronous reset, active-high
i_lsu_valid  input  1  load request valid
o_lsu_ready  output  1  unit can accept a request; high only in IDLE
i_lsu_funct3  input  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
i_lsu_addr  input  XLEN  effective byte address
i_lsu_rd_addr  input  5  destination register
o_lsu_busy  output  1  a load is in flight (state is not IDLE)
o_lsu_pending_rd  output  5  rd of the in-flight load; 0 when idle
o_lsu_fault  output  1  one-cycle pulse on misaligned, illegal or timed-out load
o_dmem_req  output  1  memory read request
o_dmem_addr  output  XLEN  word address: {addr[XLEN-1:2],2'b00}
i_dmem_gnt  input  1  request accepted
i_dmem_rvalid  input  1  read data valid
i_dmem_rdata  input  XLEN  read word
o_regfile_rd_wen  output  1  register-file write enable
o_regfile_rd_addr  output  5  register-file write address
o_regfile_rd_data  output  XLEN  register-file write data

Behaviour:
- All outputs are registered. Reset is asynchronous and active-high.
- Reset values: state IDLE; o_lsu_ready=1; every other output 0; timeout counter 0.
- FSM states: IDLE, REQ, WAIT, WB.
- IDLE, on i_lsu_valid&&o_lsu_ready:
  - Latch funct3, addr[1:0] and rd.
  - Illegal funct3 (011, 110, 111), LH/LHU with addr[0]=1, or LW with addr[1:0]!=0: o_lsu_fault=1 next cycle; no memory request; stay IDLE.
  - Otherwise go to REQ; o_dmem_req and o_dmem_addr are valid the next cycle.
- REQ: hold o_dmem_req=1 and o_dmem_addr stable until i_dmem_gnt.
  - On gnt: drop req; go to WAIT.
  - On gnt&&rvalid in the same cycle: capture rdata; go to WB.
- WAIT:
  - On i_dmem_rvalid: capture rdata; go to WB.
  - Counter increments each WAIT cycle. When it reaches TIMEOUT_CYCLES: fault pulse, no writeback, go to IDLE.
  - The counter clears on entering WAIT.
- WB: for exactly one cycle, drive o_regfile_rd_wen=1, rd_addr=latched rd, rd_data=extracted value; go to IDLE.
  - If rd==0: wen stays 0; the state still passes through WB.
- Extraction (offset = latched addr[1:0]):
  - LB/LBU: byte rdata[8*off+7:8*off], sign- or zero-extended.
  - LH/LHU: halfword at rdata[16*off[1]+15:16*off[1]], sign- or zero-extended.
  - LW: full word.
- Latency with gnt and rvalid both on the first REQ cycle: accept at cycle N, req at N+1, wen at N+2.
- Status outputs:
  - o_lsu_busy=1 in REQ, WAIT and WB.
  - o_lsu_pending_rd=latched rd in those states, 0 in IDLE.
- Ignored inputs:
  - i_dmem_rvalid is ignored in IDLE and in REQ without gnt, including stale responses after reset.
  - i_lsu_valid is ignored while not ready.
- Reset mid-operation: immediate return to IDLE with reset output values; no partial writeback.

Decomposition:
- Shared package/configs file holds XLEN and load funct3 constants (LB, LH, LW, LBU, LHU).
- One natural sub-module: riscv_load_extract, combinational; inputs funct3, offset and word; output is the extended value.
- The FSM and the timeout counter stay in the top module.

Test Plan:
- LW addr 0x100, gnt and rvalid on the first REQ cycle with rdata 0xDEADBEEF, rd=5 -> o_dmem_addr=0x100 at N+1; wen=1, rd_addr=5, data 0xDEADBEEF at N+2.
- LB addr 0x203, rdata 0x80FF_1234 -> data 0xFFFFFF80. LBU at the same address -> 0x00000080. LH addr 0x202 -> 0xFFFF80FF.
- LH addr 0x101 -> o_lsu_fault pulse one cycle later, o_dmem_req never asserted, wen stays 0. funct3=011 -> same response.
- gnt delayed 3 cycles, rvalid 4 cycles after gnt -> req held with a stable address; busy=1 and pending_rd=rd throughout; exactly one wen pulse.
- TIMEOUT_CYCLES=4 with rvalid never arriving -> fault pulse after 4 WAIT cycles, return to IDLE, o_lsu_ready=1, no wen.
- i_rst asserted in WAIT, then rvalid arrives after release -> all outputs 0 during reset; the later rvalid is ignored; no write; rd=0 load completes with wen=0.
